rename_regfile_mp: RTL and testbench

- Parametrised successor to the single-issue renaming register file.
- Holds architectural register values plus a per-register rename tag (the pending ROB entry; tag 0 means the value is ready).
- Each cycle it accepts a group of up to NISSUE decoded instructions, reads their sources with in-group dependency resolution and same-cycle commit bypass, and records each writer's tag.
- Results go out through a registered valid/ready dispatch stage to the RS/LSB dispatcher. Accepts up to NCOMMIT ROB commits per cycle and supports flush on misprediction.

---
 rtl/rename_regfile_mp.sv | 156 +++++++++++++++
 tb/tb_rename_regfile_mp.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile_mp.sv
// Multi-issue renaming register file: group source lookup with in-group
// forwarding and commit bypass, registered valid/ready dispatch stage.
module rename_regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int RNM_W   = 5,
  parameter int TAG_W   = 4,
  parameter int NISSUE  = 2,
  parameter int NCOMMIT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NISSUE-1:0]        in_slot_vld,
  input  logic [NISSUE*RNM_W-1:0]  in_rs1,
  input  logic [NISSUE*RNM_W-1:0]  in_rs2,
  input  logic [NISSUE*RNM_W-1:0]  in_rd,
  input  logic [NISSUE-1:0]        in_rd_wen,
  input  logic [NISSUE*TAG_W-1:0]  in_tag,
  input  logic [NCOMMIT-1:0]       cm_vld,
  input  logic [NCOMMIT*RNM_W-1:0] cm_rd,
  input  logic [NCOMMIT*TAG_W-1:0] cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]  cm_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NISSUE-1:0]        out_slot_vld,
  output logic [NISSUE*TAG_W-1:0]  out_rs1_tag,
  output logic [NISSUE*TAG_W-1:0]  out_rs2_tag,
  output logic [NISSUE*XLEN-1:0]   out_rs1_data,
  output logic [NISSUE*XLEN-1:0]   out_rs2_data
);

  logic [XLEN-1:0]  data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [XLEN-1:0]  data_d [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];

  logic [RNM_W-1:0] src  [NISSUE][2];
  logic [RNM_W-1:0] rd   [NISSUE];
  logic [TAG_W-1:0] itag [NISSUE];
  logic [RNM_W-1:0] crd  [NCOMMIT];
  logic [TAG_W-1:0] ctag [NCOMMIT];
  logic [XLEN-1:0]  cdat [NCOMMIT];

  logic [TAG_W-1:0] lk_tag  [NISSUE][2];
  logic [XLEN-1:0]  lk_data [NISSUE][2];

  logic accept;

  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin : unpack
    for (int k = 0; k < NISSUE; k++) begin
      src[k][0] = in_rs1[k*RNM_W +: RNM_W];
      src[k][1] = in_rs2[k*RNM_W +: RNM_W];
      rd[k]     = in_rd[k*RNM_W +: RNM_W];
      itag[k]   = in_tag[k*TAG_W +: TAG_W];
    end
    for (int c = 0; c < NCOMMIT; c++) begin
      crd[c]  = cm_rd[c*RNM_W +: RNM_W];
      ctag[c] = cm_tag[c*TAG_W +: TAG_W];
      cdat[c] = cm_data[c*XLEN +: XLEN];
    end
  end

  // Priority grows down the block: stored, commit bypass, earlier slot.
  always_comb begin : lookup
    for (int k = 0; k < NISSUE; k++) begin
      for (int s = 0; s < 2; s++) begin
        lk_tag[k][s]  = '0;
        lk_data[k][s] = '0;
        if (in_slot_vld[k] && src[k][s] != '0) begin
          lk_tag[k][s]  = tag_q[src[k][s]];
          lk_data[k][s] = data_q[src[k][s]];
          for (int c = 0; c < NCOMMIT; c++) begin
            if (cm_vld[c] && crd[c] == src[k][s] &&
                tag_q[src[k][s]] != '0 &&
                ctag[c] == tag_q[src[k][s]]) begin
              lk_tag[k][s]  = '0;
              lk_data[k][s] = cdat[c];
            end
          end
          for (int j = 0; j < NISSUE; j++) begin
            if (j < k && in_slot_vld[j] && in_rd_wen[j] &&
                rd[j] == src[k][s]) begin
              lk_tag[k][s]  = itag[j];
              lk_data[k][s] = '0;
            end
          end
        end
      end
    end
  end

  // Rename is applied after commit so it overrides a same-cycle clear.
  always_comb begin : next_state
    data_d = data_q;
    tag_d  = tag_q;
    for (int c = 0; c < NCOMMIT; c++) begin
      if (cm_vld[c] && crd[c] != '0) begin
        data_d[crd[c]] = cdat[c];
        if (tag_q[crd[c]] == ctag[c])
          tag_d[crd[c]] = '0;
      end
    end
    if (flush) begin
      for (int r = 0; r < NREG; r++)
        tag_d[r] = '0;
    end else if (accept) begin
      for (int k = 0; k < NISSUE; k++) begin
        if (in_slot_vld[k] && in_rd_wen[k] && rd[k] != '0)
          tag_d[rd[k]] = itag[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_slot_vld <= '0;
      out_rs1_tag  <= '0;
      out_rs2_tag  <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_slot_vld <= in_slot_vld;
      for (int k = 0; k < NISSUE; k++) begin
        out_rs1_tag[k*TAG_W +: TAG_W] <= lk_tag[k][0];
        out_rs2_tag[k*TAG_W +: TAG_W] <= lk_tag[k][1];
        out_rs1_data[k*XLEN +: XLEN]  <= lk_data[k][0];
        out_rs2_data[k*XLEN +: XLEN]  <= lk_data[k][1];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Directed bench for rename_regfile_mp with a per-cycle reference model
// of the register/tag state and the dispatch stage.
module tb_rename_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = 5;
  localparam int TW   = 4;
  localparam int NI   = 2;
  localparam int NC   = 2;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [NI-1:0]      in_slot_vld, in_rd_wen, out_slot_vld;
  logic [NI*RW-1:0]   in_rs1, in_rs2, in_rd;
  logic [NI*TW-1:0]   in_tag, out_rs1_tag, out_rs2_tag;
  logic [NC-1:0]      cm_vld;
  logic [NC*RW-1:0]   cm_rd;
  logic [NC*TW-1:0]   cm_tag;
  logic [NC*XLEN-1:0] cm_data;
  logic [NI*XLEN-1:0] out_rs1_data, out_rs2_data;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rename_regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .RNM_W(RW),
    .TAG_W(TW), .NISSUE(NI), .NCOMMIT(NC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_vld(in_slot_vld),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_tag(in_tag),
    .cm_vld(cm_vld), .cm_rd(cm_rd),
    .cm_tag(cm_tag), .cm_data(cm_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_slot_vld(out_slot_vld),
    .out_rs1_tag(out_rs1_tag), .out_rs2_tag(out_rs2_tag),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural state and expected dispatch stage
  logic [XLEN-1:0] m_data [NREG];
  logic [TW-1:0]   m_tag  [NREG];
  logic            exp_valid;
  logic [NI-1:0]   exp_slot;
  logic [TW-1:0]   exp_t1 [NI];
  logic [TW-1:0]   exp_t2 [NI];
  logic [XLEN-1:0] exp_d1 [NI];
  logic [XLEN-1:0] exp_d2 [NI];
  logic            started = 1'b0;

  function automatic void resolve(input int k, input logic [RW-1:0] s,
                                  output logic [TW-1:0] t,
                                  output logic [XLEN-1:0] d);
    t = '0;
    d = '0;
    if (!in_slot_vld[k] || s == 0) return;
    for (int j = k - 1; j >= 0; j--)
      if (in_slot_vld[j] && in_rd_wen[j] && in_rd[j*RW +: RW] == s) begin
        t = in_tag[j*TW +: TW];
        return;
      end
    if (m_tag[s] != 0)
      for (int c = NC - 1; c >= 0; c--)
        if (cm_vld[c] && cm_rd[c*RW +: RW] == s &&
            cm_tag[c*TW +: TW] == m_tag[s]) begin
          d = cm_data[c*XLEN +: XLEN];
          return;
        end
    t = m_tag[s];
    d = m_data[s];
  endfunction

  function automatic bit renamed(input logic acc, input logic [RW-1:0] r);
    if (!acc) return 0;
    for (int k = 0; k < NI; k++)
      if (in_slot_vld[k] && in_rd_wen[k] && in_rd[k*RW +: RW] == r)
        return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic acc;
    logic [TW-1:0] old_tag [NREG];
    if (rst) begin
      started = 1'b1;
      exp_valid = 1'b0;
      exp_slot = '0;
      for (int r = 0; r < NREG; r++) begin
        m_data[r] = '0;
        m_tag[r]  = '0;
      end
      for (int k = 0; k < NI; k++) begin
        exp_t1[k] = '0; exp_t2[k] = '0;
        exp_d1[k] = '0; exp_d2[k] = '0;
      end
    end else begin
      acc = in_valid && !flush && (!exp_valid || out_ready);
      if (acc) begin
        exp_valid = 1'b1;
        exp_slot  = in_slot_vld;
        for (int k = 0; k < NI; k++) begin
          resolve(k, in_rs1[k*RW +: RW], exp_t1[k], exp_d1[k]);
          resolve(k, in_rs2[k*RW +: RW], exp_t2[k], exp_d2[k]);
        end
      end else if (flush || out_ready) begin
        exp_valid = 1'b0;
      end
      old_tag = m_tag;
      for (int c = 0; c < NC; c++) begin
        logic [RW-1:0] r;
        r = cm_rd[c*RW +: RW];
        if (cm_vld[c] && r != 0) begin
          m_data[r] = cm_data[c*XLEN +: XLEN];
          if (old_tag[r] == cm_tag[c*TW +: TW] && !renamed(acc, r))
            m_tag[r] = '0;
        end
      end
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_tag[r] = '0;
      end else if (acc) begin
        for (int k = 0; k < NI; k++)
          if (in_slot_vld[k] && in_rd_wen[k] && in_rd[k*RW +: RW] != 0)
            m_tag[in_rd[k*RW +: RW]] = in_tag[k*TW +: TW];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready,
          !rst && !flush && (!exp_valid || out_ready));
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        for (int k = 0; k < NI; k++) begin
          chk($sformatf("slot_vld[%0d]", k), out_slot_vld[k], exp_slot[k]);
          chk($sformatf("rs1_tag[%0d]", k), out_rs1_tag[k*TW +: TW], exp_t1[k]);
          chk($sformatf("rs2_tag[%0d]", k), out_rs2_tag[k*TW +: TW], exp_t2[k]);
          chk($sformatf("rs1_data[%0d]", k), out_rs1_data[k*XLEN +: XLEN], exp_d1[k]);
          chk($sformatf("rs2_data[%0d]", k), out_rs2_data[k*XLEN +: XLEN], exp_d2[k]);
        end
      end
    end
  end

  function automatic logic [TW-1:0] t1(input int k);
    return out_rs1_tag[k*TW +: TW];
  endfunction
  function automatic logic [TW-1:0] t2(input int k);
    return out_rs2_tag[k*TW +: TW];
  endfunction
  function automatic logic [XLEN-1:0] d1(input int k);
    return out_rs1_data[k*XLEN +: XLEN];
  endfunction
  function automatic logic [XLEN-1:0] d2(input int k);
    return out_rs2_data[k*XLEN +: XLEN];
  endfunction

  task automatic clr_in();
    flush = 0; in_valid = 0;
    in_slot_vld = '0; in_rs1 = '0; in_rs2 = '0;
    in_rd = '0; in_rd_wen = '0; in_tag = '0;
    cm_vld = '0; cm_rd = '0; cm_tag = '0; cm_data = '0;
  endtask

  task automatic slot(input int k, input logic v,
                      input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                      input logic [RW-1:0] d, input logic w,
                      input logic [TW-1:0] t);
    in_valid = 1;
    in_slot_vld[k] = v;
    in_rs1[k*RW +: RW] = r1;
    in_rs2[k*RW +: RW] = r2;
    in_rd[k*RW +: RW] = d;
    in_rd_wen[k] = w;
    in_tag[k*TW +: TW] = t;
  endtask

  task automatic commit(input int c, input logic [RW-1:0] r,
                        input logic [TW-1:0] t, input logic [XLEN-1:0] d);
    cm_vld[c] = 1;
    cm_rd[c*RW +: RW] = r;
    cm_tag[c*TW +: TW] = t;
    cm_data[c*XLEN +: XLEN] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; out_ready = 1;
    clr_in();
    tick(); tick();
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst rs1_tag", out_rs1_tag, 0);
    rst = 0;

    // 1: basic lookup after reset
    slot(0, 1, 5, 0, 0, 0, 0);
    tick();
    chk("t1 out_valid", out_valid, 1);
    chk("t1 rs1_tag", t1(0), 0);
    chk("t1 rs2_data", d2(0), 0);

    // 2: in-group forward, stored tag, commit bypass
    clr_in();
    slot(0, 1, 0, 0, 3, 1, 4);
    slot(1, 1, 3, 0, 0, 0, 0);
    tick();
    chk("t2 fwd tag", t1(1), 4);
    clr_in();
    slot(0, 1, 3, 0, 0, 0, 0);
    tick();
    chk("t2 stored tag", t1(0), 4);
    clr_in();
    slot(0, 1, 3, 0, 0, 0, 0);
    commit(0, 3, 4, 32'hDEADBEEF);
    tick();
    chk("t2 byp tag", t1(0), 0);
    chk("t2 byp data", d1(0), 32'hDEADBEEF);
    clr_in();
    slot(0, 1, 3, 0, 0, 0, 0);
    tick();
    chk("t2 cleared tag", t1(0), 0);

    // 3: stale commit keeps the newer tag
    clr_in(); slot(0, 1, 0, 0, 7, 1, 2); tick();
    clr_in(); slot(0, 1, 0, 0, 7, 1, 5); tick();
    clr_in(); commit(0, 7, 2, 32'h11); tick();
    chk("t3 drained", out_valid, 0);
    clr_in(); slot(0, 1, 7, 7, 0, 0, 0); tick();
    chk("t3 tag", t1(0), 5);
    chk("t3 data", d1(0), 32'h11);

    // 4: backpressure
    clr_in();
    out_ready = 0;
    slot(0, 1, 3, 0, 0, 0, 0);
    #1 chk("t4 in_ready lo", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4 hold valid", out_valid, 1);
      chk("t4 hold tag", t1(0), 5);
      chk("t4 hold data", d1(0), 32'h11);
    end
    out_ready = 1;
    #1 chk("t4 in_ready hi", in_ready, 1);
    tick();
    chk("t4 new data", d1(0), 32'hDEADBEEF);

    // 5: flush with same-cycle commit
    clr_in();
    slot(0, 1, 0, 0, 1, 1, 1);
    slot(1, 1, 0, 0, 2, 1, 2);
    tick();
    clr_in(); slot(0, 1, 0, 0, 3, 1, 3); tick();
    clr_in();
    flush = 1;
    slot(0, 1, 2, 0, 0, 0, 0);
    commit(0, 2, 2, 32'h22);
    #1 chk("t5 in_ready", in_ready, 0);
    tick();
    chk("t5 out_valid", out_valid, 0);
    clr_in();
    slot(0, 1, 2, 1, 0, 0, 0);
    slot(1, 1, 3, 0, 0, 0, 0);
    tick();
    chk("t5 r2 tag", t1(0), 0);
    chk("t5 r2 data", d1(0), 32'h22);
    chk("t5 r1 tag", t2(0), 0);
    chk("t5 r3 data", d1(1), 32'hDEADBEEF);

    // 6: dual commit to one rd, store slot, invalid slot
    clr_in(); slot(0, 1, 0, 0, 9, 1, 6); tick();
    clr_in();
    slot(0, 1, 0, 0, 9, 0, 7);
    slot(1, 0, 3, 0, 0, 0, 0);
    commit(0, 9, 1, 32'hA);
    commit(1, 9, 2, 32'hB);
    tick();
    chk("t6 inv slot", out_slot_vld[1], 0);
    chk("t6 inv data", d1(1), 0);
    clr_in(); slot(0, 1, 9, 0, 0, 0, 0); tick();
    chk("t6 r9 tag", t1(0), 6);
    chk("t6 r9 data", d1(0), 32'hB);

    // youngest slot wins a duplicate rd
    clr_in();
    slot(0, 1, 0, 0, 4, 1, 3);
    slot(1, 1, 0, 0, 4, 1, 5);
    tick();
    clr_in(); slot(0, 1, 0, 4, 0, 0, 0); tick();
    chk("dup rd tag", t2(0), 5);

    clr_in();
    tick();
    chk("drain", out_valid, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
